// File: rtl/conv_mem_arb_if.sv
// Port bundle between the two layer engines, the arbiter and the layer memory.
// A beat moves when rX_req && rX_gnt on the same rising edge; req may drop at any time.
interface conv_mem_arb_if #(
    parameter int AW = 12,
    parameter int DW = 20,
    parameter int SW = 3
);
    logic          r0_req;
    logic          r0_we;
    logic [SW-1:0] r0_sel;
    logic [AW-1:0] r0_addr;
    logic [DW-1:0] r0_wdata;
    logic          r0_gnt;
    logic          r0_rvalid;
    logic [DW-1:0] r0_rdata;

    logic          r1_req;
    logic          r1_we;
    logic [SW-1:0] r1_sel;
    logic [AW-1:0] r1_addr;
    logic [DW-1:0] r1_wdata;
    logic          r1_gnt;
    logic          r1_rvalid;
    logic [DW-1:0] r1_rdata;

    logic          cwr;
    logic [AW-1:0] caddr_wr;
    logic [DW-1:0] cdata_wr;
    logic          crd;
    logic [AW-1:0] caddr_rd;
    logic [DW-1:0] cdata_rd;
    logic [SW-1:0] csel;
    logic          idle;
    logic [1:0]    dbg_state;

    modport slave (
        input  r0_req, r0_we, r0_sel, r0_addr, r0_wdata,
        input  r1_req, r1_we, r1_sel, r1_addr, r1_wdata,
        input  cdata_rd,
        output r0_gnt, r0_rvalid, r0_rdata,
        output r1_gnt, r1_rvalid, r1_rdata,
        output cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel, idle, dbg_state
    );

    modport master (
        output r0_req, r0_we, r0_sel, r0_addr, r0_wdata,
        output r1_req, r1_we, r1_sel, r1_addr, r1_wdata,
        output cdata_rd,
        input  r0_gnt, r0_rvalid, r0_rdata,
        input  r1_gnt, r1_rvalid, r1_rdata,
        input  cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel, idle, dbg_state
    );
endinterface

// File: rtl/conv_mem_arb.sv
// Round-robin, burst-locked arbiter giving the conv engine (R0) and max-pool engine (R1)
// the single layer-memory port; issue and read-return stages are fully registered.
module conv_mem_arb #(
    parameter int AW        = 12,
    parameter int DW        = 20,
    parameter int SW        = 3,
    parameter int MAX_BURST = 16
) (
    input  logic           clk,
    input  logic           reset,
    conv_mem_arb_if.slave  bus
);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic          last_owner, last_owner_nx;
    logic [CW-1:0] beat_cnt, beat_cnt_nx;

    logic          acc0, acc1, acc;
    logic          beat_we;
    logic [SW-1:0] beat_sel;
    logic [AW-1:0] beat_addr;
    logic [DW-1:0] beat_wdata;
    logic          iss_id;

    assign acc0       = (state == OWN0) && bus.r0_req;
    assign acc1       = (state == OWN1) && bus.r1_req;
    assign acc        = acc0 || acc1;
    assign beat_we    = acc1 ? bus.r1_we    : bus.r0_we;
    assign beat_sel   = acc1 ? bus.r1_sel   : bus.r0_sel;
    assign beat_addr  = acc1 ? bus.r1_addr  : bus.r0_addr;
    assign beat_wdata = acc1 ? bus.r1_wdata : bus.r0_wdata;

    // Burst end (count reaching MAX_BURST) only hands over when the other side waits.
    always_comb begin
        state_nx      = state;
        last_owner_nx = last_owner;
        beat_cnt_nx   = beat_cnt;
        unique case (state)
            IDLE: begin
                if (bus.r0_req && bus.r1_req) state_nx = last_owner ? OWN0 : OWN1;
                else if (bus.r0_req)          state_nx = OWN0;
                else if (bus.r1_req)          state_nx = OWN1;
            end
            OWN0: begin
                if (!bus.r0_req) begin
                    beat_cnt_nx = '0;
                    state_nx    = bus.r1_req ? OWN1 : IDLE;
                end else begin
                    last_owner_nx = 1'b0;
                    if (beat_cnt == CW'(MAX_BURST - 1)) begin
                        beat_cnt_nx = '0;
                        if (bus.r1_req) state_nx = OWN1;
                    end else begin
                        beat_cnt_nx = beat_cnt + 1'b1;
                    end
                end
            end
            OWN1: begin
                if (!bus.r1_req) begin
                    beat_cnt_nx = '0;
                    state_nx    = bus.r0_req ? OWN0 : IDLE;
                end else begin
                    last_owner_nx = 1'b1;
                    if (beat_cnt == CW'(MAX_BURST - 1)) begin
                        beat_cnt_nx = '0;
                        if (bus.r0_req) state_nx = OWN0;
                    end else begin
                        beat_cnt_nx = beat_cnt + 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            beat_cnt   <= '0;
            bus.r0_gnt <= 1'b0;
            bus.r1_gnt <= 1'b0;
        end else begin
            state      <= state_nx;
            last_owner <= last_owner_nx;
            beat_cnt   <= beat_cnt_nx;
            bus.r0_gnt <= (state_nx == OWN0);
            bus.r1_gnt <= (state_nx == OWN1);
        end
    end

    // Issue stage: address/data/select hold when no beat was accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.cwr      <= 1'b0;
            bus.crd      <= 1'b0;
            bus.caddr_wr <= '0;
            bus.cdata_wr <= '0;
            bus.caddr_rd <= '0;
            bus.csel     <= '0;
            iss_id       <= 1'b0;
        end else begin
            bus.cwr <= acc && beat_we;
            bus.crd <= acc && !beat_we;
            if (acc) begin
                bus.csel <= beat_sel;
                iss_id   <= acc1;
                if (beat_we) begin
                    bus.caddr_wr <= beat_addr;
                    bus.cdata_wr <= beat_wdata;
                end else begin
                    bus.caddr_rd <= beat_addr;
                end
            end
        end
    end

    // Read return follows the pipelined issuer id, not the current owner.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.r0_rvalid <= 1'b0;
            bus.r1_rvalid <= 1'b0;
            bus.r0_rdata  <= '0;
            bus.r1_rdata  <= '0;
        end else begin
            bus.r0_rvalid <= bus.crd && !iss_id;
            bus.r1_rvalid <= bus.crd && iss_id;
            if (bus.crd && !iss_id) bus.r0_rdata <= bus.cdata_rd;
            if (bus.crd && iss_id)  bus.r1_rdata <= bus.cdata_rd;
        end
    end

    assign bus.idle      = (state == IDLE) && !bus.cwr && !bus.crd
                           && !bus.r0_rvalid && !bus.r1_rvalid;
    assign bus.dbg_state = state;
endmodule
